// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the issue-side hazard scoreboard.
// Widths here are also used by the forwarding hazard controller.
package hazard_pkg;

  localparam int REG_COUNT  = 16;
  localparam int REG_ADDR_W = 4;
  localparam int CNT_W      = 2;
  localparam int CNT_MAX    = 3;
  localparam int INSTR_W    = 24;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  function automatic logic cnt_at_limit(input cnt_t cnt, input int limit);
    return cnt == cnt_t'(limit);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One register's outstanding-write record: write counter plus a flag that
// marks the youngest outstanding write as a load.
module scoreboard_entry
  import hazard_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic inc_is_load,
  input  logic dec,
  output cnt_t cnt,
  output logic ld
);

  cnt_t cnt_reg, cnt_next;
  logic ld_reg, ld_next;

  // dec only arrives when the counter is non-zero, so no wrap guard here
  always_comb begin
    cnt_next = cnt_reg;
    ld_next  = ld_reg;
    if (inc && dec) begin
      ld_next = inc_is_load;
    end else if (inc) begin
      cnt_next = cnt_reg + cnt_t'(1);
      ld_next  = inc_is_load;
    end else if (dec) begin
      cnt_next = cnt_reg - cnt_t'(1);
      if (cnt_reg == cnt_t'(1)) begin
        ld_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      ld_reg  <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      ld_reg  <= ld_next;
    end
  end

  assign cnt = cnt_reg;
  assign ld  = ld_reg;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks outstanding register writes between decode and ID/EX and stalls
// issue on load-use hazards or when a register's write counter is full.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_COUNT = hazard_pkg::REG_COUNT,
  parameter int CNT_MAX   = hazard_pkg::CNT_MAX
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic                  issue_write,
  input  logic                  issue_is_load,
  input  logic [REG_ADDR_W-1:0] issue_regC,
  input  logic                  use_regA,
  input  logic                  use_regB,
  input  logic [REG_ADDR_W-1:0] regA,
  input  logic [REG_ADDR_W-1:0] regB,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_regC,
  output logic                  stall,
  output logic                  issue_accept,
  output logic [REG_COUNT-1:0]  pending_mask,
  output logic                  wb_underflow
);

  cnt_t                 cnt [REG_COUNT];
  logic [REG_COUNT-1:0] ld;
  logic                 wb_empty;
  logic                 load_use;
  logic                 capacity;
  logic                 underflow_reg;

  // All hazard decisions use pre-update state, so a same-cycle write-back
  // releases a stall only on the following cycle.
  assign wb_empty     = (cnt[wb_regC] == '0);
  assign load_use     = (use_regA & ld[regA]) | (use_regB & ld[regB]);
  assign capacity     = issue_write & cnt_at_limit(cnt[issue_regC], CNT_MAX);
  assign stall        = issue_valid & (load_use | capacity);
  assign issue_accept = issue_valid & ~stall;

  generate
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_entry
      logic inc;
      logic dec;

      assign inc = issue_accept & issue_write & (issue_regC == REG_ADDR_W'(gi));
      assign dec = wb_valid & ~wb_empty & (wb_regC == REG_ADDR_W'(gi));

      scoreboard_entry u_entry (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc         (inc),
        .inc_is_load (issue_is_load),
        .dec         (dec),
        .cnt         (cnt[gi]),
        .ld          (ld[gi])
      );

      assign pending_mask[gi] = |cnt[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_reg <= 1'b0;
    end else if (wb_valid && wb_empty) begin
      underflow_reg <= 1'b1;
    end
  end

  assign wb_underflow = underflow_reg;

endmodule
